// File: rtl/ps2_tone_generator.sv
// Square-wave speaker driver fed by the PS/2 decoder's half-period word.
// Input values must hold steady before they are used; pitch changes land only on full-period boundaries.
module ps2_tone_generator #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MIN_HALF      = 2
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic [25:0] half_period,
   output logic        spk,
   output logic        playing,
   output logic        note_chg
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STAB_ONE  = SW'(1);
   localparam logic [25:0]   MIN_VAL   = 26'(MIN_HALF);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t         state;
   logic [25:0]    cand;
   logic [25:0]    qual;
   logic [25:0]    act;
   logic [25:0]    cnt;
   logic [SW-1:0]  stab_cnt;
   logic [25:0]    act_last;

   assign act_last = act - 26'd1;

   // Qualifier: a value is accepted only after STABLE_CYCLES identical samples.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         cand     <= '0;
         stab_cnt <= '0;
         qual     <= '0;
      end else if (half_period == cand) begin
         if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + STAB_ONE;
         if (stab_cnt == STAB_LAST)
            qual <= cand;
      end else begin
         cand     <= half_period;
         stab_cnt <= STAB_ONE;
         // With a one-sample window the first differing sample is already qualified.
         if (STABLE_CYCLES == 1)
            qual <= half_period;
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         act      <= '0;
         spk      <= 1'b0;
         playing  <= 1'b0;
         note_chg <= 1'b0;
      end else begin
         note_chg <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               spk     <= 1'b0;
               playing <= 1'b0;
               if (qual >= MIN_VAL) begin
                  act      <= qual;
                  state    <= HIGH;
                  spk      <= 1'b1;
                  playing  <= 1'b1;
                  note_chg <= 1'b1;
               end
            end
            HIGH: begin
               if (cnt == act_last) begin
                  cnt   <= '0;
                  spk   <= 1'b0;
                  state <= LOW;
               end else begin
                  cnt <= cnt + 26'd1;
               end
            end
            LOW: begin
               // End of LOW is the only point where act may be replaced.
               if (cnt == act_last) begin
                  cnt <= '0;
                  if (qual < MIN_VAL) begin
                     state   <= IDLE;
                     playing <= 1'b0;
                  end else begin
                     state <= HIGH;
                     spk   <= 1'b1;
                     if (qual != act) begin
                        act      <= qual;
                        note_chg <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 26'd1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               spk     <= 1'b0;
               playing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_tone_generator.sv
// Randomized bench for ps2_tone_generator against a sample-history / period-position model.
module tb_ps2_tone_generator;

   localparam int S = 4;
   localparam int M = 2;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic [25:0] half_period;
   logic        spk;
   logic        playing;
   logic        note_chg;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: recent samples, accepted value, and position within the current period.
   logic [25:0] samples[$];
   int m_qual;
   bit m_play;
   int m_act;
   int m_pos;
   bit m_note;

   always #5 CLK = ~CLK;

   ps2_tone_generator #(.STABLE_CYCLES(S), .MIN_HALF(M)) dut (
      .CLK(CLK),
      .rst_n(rst_n),
      .half_period(half_period),
      .spk(spk),
      .playing(playing),
      .note_chg(note_chg)
   );

   function automatic logic [2:0] exp_out();
      logic s;
      s = (m_play && (m_pos < m_act)) ? 1'b1 : 1'b0;
      return {s, logic'(m_play), logic'(m_note)};
   endfunction

   task automatic tick(input logic rstv, input logic [25:0] hp);
      int qprev;
      bit same;
      rst_n = rstv;
      half_period = hp;
      @(posedge CLK);
      if (!rstv) begin
         samples.delete();
         m_qual = 0; m_play = 0; m_act = 0; m_pos = 0; m_note = 0;
      end else begin
         qprev = m_qual;
         samples.push_back(hp);
         if (samples.size() > S) void'(samples.pop_front());
         if (samples.size() == S) begin
            same = 1;
            foreach (samples[i]) if (samples[i] != hp) same = 0;
            if (same) m_qual = int'(hp);
         end
         m_note = 0;
         if (!m_play) begin
            if (qprev >= M) begin
               m_play = 1; m_act = qprev; m_pos = 0; m_note = 1;
            end
         end else begin
            m_pos++;
            if (m_pos == 2 * m_act) begin
               m_pos = 0;
               if (qprev < M) m_play = 0;
               else begin
                  if (qprev != m_act) m_note = 1;
                  m_act = qprev;
               end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 26'd5);
         vectors++;
         if ({spk, playing, note_chg} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold cyc=%0d got=%b want=000", i, {spk, playing, note_chg});
         end
      end
      for (int i = 1; i <= 3; i++) begin
         tick(1'b1, 26'd5);
         vectors++;
         if ({spk, playing, note_chg} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release edge=%0d got=%b want=000", i, {spk, playing, note_chg});
         end
      end
   endtask

   task automatic test_start_up();
      logic [2:0] want;
      tick(1'b0, 26'd0);
      tick(1'b0, 26'd0);
      for (int e = 1; e <= 16; e++) begin
         tick(1'b1, 26'd5);
         want = {logic'((e >= 5 && e <= 9) || e >= 15), logic'(e >= 5), logic'(e == 5)};
         vectors++;
         if ({spk, playing, note_chg} !== want) begin
            miscompares++;
            $display("FAIL start_up edge=%0d got=%b want=%b", e, {spk, playing, note_chg}, want);
         end
         vectors++;
         if ({spk, playing, note_chg} !== exp_out()) begin
            miscompares++;
            $display("FAIL start_up_model edge=%0d got=%b want=%b", e, {spk, playing, note_chg}, exp_out());
         end
      end
   endtask

   task automatic test_glitch();
      logic [25:0] g;
      int pre, nc, last_rise, cyc;
      logic prev;
      g = 26'(6 + $urandom_range(0, 10));
      pre = int'($urandom_range(0, 7));
      nc = 0; last_rise = -1; cyc = 0; prev = spk;
      for (int i = 0; i < pre + 3 + 30; i++) begin
         tick(1'b1, (i >= pre && i < pre + 3) ? g : 26'd5);
         cyc++;
         if (note_chg === 1'b1) nc++;
         if (spk === 1'b1 && prev === 1'b0) begin
            if (last_rise >= 0) begin
               vectors++;
               if (cyc - last_rise !== 10) begin
                  miscompares++;
                  $display("FAIL glitch_period got=%0d want=10", cyc - last_rise);
               end
            end
            last_rise = cyc;
         end
         prev = spk;
         vectors++;
         if ({spk, playing, note_chg} !== exp_out()) begin
            miscompares++;
            $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, {spk, playing, note_chg}, exp_out());
         end
      end
      vectors++;
      if (nc !== 0) begin
         miscompares++;
         $display("FAIL glitch_note_chg got=%0d want=0", nc);
      end
   endtask

   task automatic wait_rise(input logic [25:0] hp, input string tag);
      logic prev;
      bit found;
      prev = spk; found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1'b1, hp);
         if (spk === 1'b1 && prev === 1'b0) found = 1;
         prev = spk;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL %s_rise_timeout got=none want=rise", tag);
      end
   endtask

   task automatic test_silence();
      int k;
      wait_rise(26'd5, "silence");
      k = 0;
      for (int i = 1; i <= 30 && k == 0; i++) begin
         tick(1'b1, 26'd0);
         if (playing === 1'b0) k = i;
         vectors++;
         if ({spk, playing, note_chg} !== exp_out()) begin
            miscompares++;
            $display("FAIL silence_model edge=%0d got=%b want=%b", i, {spk, playing, note_chg}, exp_out());
         end
      end
      vectors++;
      if (k !== 10) begin
         miscompares++;
         $display("FAIL silence_latency got=%0d want=10", k);
      end
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 26'd1);
         vectors++;
         if ({spk, playing, note_chg} !== 3'b000) begin
            miscompares++;
            $display("FAIL min_half cyc=%0d got=%b want=000", i, {spk, playing, note_chg});
         end
      end
   endtask

   task automatic test_mid_change(output int nv);
      int k;
      logic want;
      nv = int'($urandom_range(3, 4));
      wait_rise(26'd5, "mid");
      k = 0;
      for (int i = 1; i <= 30 && k == 0; i++) begin
         tick(1'b1, 26'(nv));
         if (note_chg === 1'b1) k = i;
         vectors++;
         if ({spk, playing, note_chg} !== exp_out()) begin
            miscompares++;
            $display("FAIL mid_model edge=%0d got=%b want=%b", i, {spk, playing, note_chg}, exp_out());
         end
      end
      vectors++;
      if (k !== 10) begin
         miscompares++;
         $display("FAIL mid_note_latency got=%0d want=10", k);
      end
      for (int j = 1; j < 4 * nv; j++) begin
         tick(1'b1, 26'(nv));
         want = ((j % (2 * nv)) < nv) ? 1'b1 : 1'b0;
         vectors++;
         if ({spk, note_chg} !== {want, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_new_pitch j=%0d got=%b want=%b", j, {spk, note_chg}, {want, 1'b0});
         end
      end
   endtask

   task automatic test_reset_mid(input int nv);
      int k;
      wait_rise(26'(nv), "rst_mid");
      tick(1'b1, 26'(nv));
      tick(1'b1, 26'(nv));
      tick(1'b0, 26'(nv));
      vectors++;
      if ({spk, playing, note_chg} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_mid got=%b want=000", {spk, playing, note_chg});
      end
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         tick(1'b1, 26'(nv));
         if (spk === 1'b1) k = i;
      end
      vectors++;
      if (k !== S + 1) begin
         miscompares++;
         $display("FAIL reset_mid_requalify got=%0d want=%0d", k, S + 1);
      end
   endtask

   task automatic test_random();
      logic [25:0] v;
      int len;
      logic r;
      for (int seg = 0; seg < 300; seg++) begin
         v = 26'($urandom_range(0, 7));
         len = int'($urandom_range(1, 20));
         for (int i = 0; i < len; i++) begin
            r = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick(r, v);
            vectors++;
            if ({spk, playing, note_chg} !== exp_out()) begin
               miscompares++;
               $display("FAIL random_model seg=%0d val=%0d got=%b want=%b", seg, v, {spk, playing, note_chg}, exp_out());
            end
         end
      end
   endtask

   initial begin
      int nv;
      rst_n = 1'b0;
      half_period = '0;
      test_reset();
      test_start_up();
      test_glitch();
      test_silence();
      test_mid_change(nv);
      test_reset_mid(nv);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_tone_generator.md
# ps2_tone_generator

Square-wave tone generator sitting directly downstream of the PS/2 scan-code decoder. It consumes the decoder's 26-bit half-period word (`FinalNote`, in CLK cycles; 0 = no note) and drives the speaker pin. It filters transient codes while the decoder is shifting bits in, and changes pitch only at full-period boundaries, so every period the block emits has exactly 50 % duty.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive identical input samples required before a half-period value is accepted (≥1).
- `MIN_HALF`, default 2: accepted values below this are treated as silence.
- `CLK`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `half_period`  in  26  half-period from the decoder; 0 = silence. Treated as synchronous to CLK.
- `spk`  out  1  speaker square wave.
- `playing`  out  1  high while state is HIGH or LOW.
- `note_chg`  out  1  one-cycle pulse when a new tone value is loaded.

## Operation
- Qualifier:
  - Registers `cand` (26 b) and `stab_cnt`.
  - If the sampled `half_period` equals `cand`, `stab_cnt` increments, saturating at `STABLE_CYCLES`. Otherwise `cand` ← input and `stab_cnt` ← 1.
  - `qual` ← `cand` on the edge where `stab_cnt` reaches `STABLE_CYCLES`. The sample on that edge is the `STABLE_CYCLES`-th equal one.
  - `qual` resets to 0.
- Generator FSM:
  - IDLE: `spk`=0, `cnt`=0, `playing`=0. If `qual` ≥ `MIN_HALF`: `act` ← `qual`, go to HIGH, `spk` ← 1, `note_chg` pulses.
  - HIGH: `cnt` increments each cycle. When `cnt` = `act`−1: `cnt` ← 0, `spk` ← 0, go to LOW.
  - LOW: `cnt` increments each cycle. When `cnt` = `act`−1 (full-period boundary), exactly one of:
    - `qual` < `MIN_HALF`: go to IDLE, `spk` stays 0.
    - `qual` = `act`: go to HIGH, `spk` ← 1.
    - `qual` differs and ≥ `MIN_HALF`: `act` ← `qual`, go to HIGH, `spk` ← 1, `note_chg` pulses.
- `act` is never changed inside a period. Mid-period `qual` changes wait for the boundary.
- `cnt` and `act` are 26 b unsigned. Comparison `cnt == act-1` is valid because `act` ≥ `MIN_HALF` ≥ 1.
- Reset values: `spk`=0, `playing`=0, `note_chg`=0, state IDLE, `cnt`=0, `act`=0, `qual`=0, `cand`=0, `stab_cnt`=0.
- Reset asserted mid-tone: all of the above on the next edge; no partial half-period is completed.

## Timing
- Qualification latency: a value first presented before edge E is in `qual` after edge E+`STABLE_CYCLES`−1.
- IDLE start: if `qual` becomes valid after edge Q, then `spk`=1, `playing`=1 and `note_chg`=1 all hold after edge Q+1.
- Each half-period is exactly `act` cycles. Full period = 2·`act` cycles.
- `note_chg` is high for one cycle, coincident with the `spk` rising edge of the new tone.
- Pitch change latency: up to 2·`act` cycles after `qual` updates, landing at the end of the current LOW phase.
- Silence latency: same; a tone always finishes its current full period.
- A glitch of fewer than `STABLE_CYCLES` cycles never reaches `qual`. After the glitch, the original value must re-qualify for a full `STABLE_CYCLES` (`cand` was overwritten) before `qual` can change again. While it re-qualifies, `qual` keeps its last value, so the tone is undisturbed.

## Test plan
- Reset: hold `rst_n`=0 three cycles with `half_period`=5 → `spk`=0, `playing`=0, `note_chg`=0 throughout. Release → no toggle before qualification.
- Start-up, `STABLE_CYCLES`=4, `MIN_HALF`=2: input 5 applied at edge 1 → `qual`=5 after edge 4. `spk`=1 and `note_chg`=1 after edge 5. `spk` falls after edge 10, rises after edge 15. `note_chg` stays 0 after edge 6.
- Glitch filter: steady 5, then input 9 for 3 cycles, then back to 5 → `spk` period stays 10 cycles, no `note_chg`.
- Mid-period change: while playing 5, input 3 qualifies during a HIGH phase → current HIGH and LOW stay 5 cycles each. Then `note_chg` pulses, followed by 3/3-cycle half-periods.
- Silence and MIN_HALF: input 0 qualifies mid-HIGH → the period completes, then IDLE with `spk`=0, `playing`=0. Input 1 qualified from IDLE → stays IDLE.
- Reset mid-tone: assert `rst_n`=0 while in HIGH with `cnt`=2 → after that edge `spk`=0, `playing`=0. After release with input unchanged, re-qualification takes the full `STABLE_CYCLES` again.
